// File: rtl/uart_rx_driver.sv
// uart_rx_driver: single-clock 8N1 UART receiver, LSB first.
// The bytes it recovers are presented with a one-cycle out_ready pulse.
// A stop bit sampled low raises a one-cycle frame_err pulse.
// Optional feature macro: UART_RX_MAJORITY_EN. When it is defined, each bit
// decision takes a 3-sample majority vote instead of a single rxd_s sample.
module uart_rx_driver #(
  parameter int unsigned BAUD_PERIOD = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] out,
  output logic       out_ready,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(BAUD_PERIOD) + 1;
  localparam int unsigned HALF  = BAUD_PERIOD / 2;

  localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BAUD_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       out_q, out_d;
  logic             out_ready_q, out_ready_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             rxd_meta_q, rxd_meta_d;
  logic             rxd_s_q, rxd_s_d;
  logic             samp_c;

`ifdef UART_RX_MAJORITY_EN
  // The two previous rxd_s values. Together with the current rxd_s they form the 3-sample window.
  logic [1:0]       hist_q, hist_d;
`endif

  // Two-flop synchronizer on rxd, plus the sample value used for bit decisions
  always_comb begin
    rxd_meta_d = rxd;
    rxd_s_d    = rxd_meta_q;
`ifdef UART_RX_MAJORITY_EN
    hist_d = {hist_q[0], rxd_s_q};
    samp_c = (rxd_s_q & hist_q[0]) | (rxd_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    samp_c = rxd_s_q;
`endif
  end

  // Synchronizer and sample-history registers; the line idles high after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      hist_q     <= 2'b11;
`endif
    end else begin
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q     <= hist_d;
`endif
    end
  end

  // Next-state, bit-timing and registered-output logic of the receive FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    out_d       = out_q;
    out_ready_d = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF_M1) begin
          cnt_d = '0;
          if (!samp_c) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {samp_c, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (samp_c) begin
            out_d       = shreg_q;
            out_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BRK;
          end
        end
      end
      S_BRK: begin
        // A line held low must not start a new frame. Wait until it goes high again.
        cnt_d = '0;
        if (rxd_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // FSM state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shreg_q     <= 8'h00;
      out_q       <= 8'h00;
      out_ready_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      out_q       <= out_d;
      out_ready_q <= out_ready_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign out       = out_q;
  assign out_ready = out_ready_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_driver.sv
// Directed bench for uart_rx_driver running at 16 clock cycles per bit.
module tb_uart_rx_driver;

  localparam int unsigned BP   = 16;
  localparam int unsigned HALF = BP / 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] out;
  logic       out_ready;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int cyc      = 0;
  int rdy_n    = 0;
  int ferr_n   = 0;
  int both_n   = 0;
  int pulse_cyc [0:31];
  logic [7:0] pulse_byte [0:31];
  int t_first;
  logic [7:0] exp_glitch;

  uart_rx_driver #(.BAUD_PERIOD(BP)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .out       (out),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the output pulses away from the active edge
  always @(negedge clk) begin
    if (out_ready) begin
      if (rdy_n < 32) begin
        pulse_cyc[rdy_n]  = cyc;
        pulse_byte[rdy_n] = out;
      end
      rdy_n = rdy_n + 1;
    end
    if (frame_err) ferr_n = ferr_n + 1;
    if (out_ready && frame_err) both_n = both_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      failures = failures + 1;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rxd = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // Drive the first ncyc cycles of an 8N1 frame. glitch_mask inverts rxd for one
  // cycle at the mid-bit sample point of each selected data bit.
  task automatic drive_frame(input logic [7:0] b, input logic stop_val,
                             input logic [7:0] glitch_mask, input int ncyc);
    logic [7:0] bb;
    logic [7:0] gm;
    logic       v;
    int         fb;
    bb = b;
    gm = glitch_mask;
    for (int c = 0; c < ncyc; c++) begin
      fb = c / BP;
      if (fb == 0)      v = 1'b0;
      else if (fb <= 8) v = bb[fb-1];
      else              v = stop_val;
      if (fb >= 1 && fb <= 8 && gm[fb-1] && c == int'(HALF) + fb * int'(BP)) v = ~v;
      rxd = v;
      @(posedge clk); #1;
    end
  endtask

  initial begin
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'h96;
`else
    exp_glitch = 8'h69;
`endif
    rxd   = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out",       32'(out), 32'h00);
    chk("reset_out_ready", 32'(out_ready), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_busy",      32'(busy), 32'h0);
    reset = 1'b0;
    idle(5);

    // Single good frame
    drive_frame(8'hA5, 1'b1, 8'h00, 10 * BP);
    idle(8);
    chk("a5_pulses", 32'(rdy_n), 32'd1);
    chk("a5_byte",   32'(pulse_byte[0]), 32'hA5);
    chk("a5_out",    32'(out), 32'hA5);
    chk("a5_ferr",   32'(ferr_n), 32'd0);
    chk("a5_busy",   32'(busy), 32'h0);

    // Back-to-back frames with no idle gap between them
    drive_frame(8'h00, 1'b1, 8'h00, 10 * BP);
    drive_frame(8'hFF, 1'b1, 8'h00, 10 * BP);
    idle(8);
    chk("b2b_pulses", 32'(rdy_n), 32'd3);
    chk("b2b_byte0",  32'(pulse_byte[1]), 32'h00);
    chk("b2b_byte1",  32'(pulse_byte[2]), 32'hFF);
    t_first = pulse_cyc[1];
    chk("b2b_spacing", 32'(pulse_cyc[2] - t_first), 32'd160);

    // Short low glitch: START rejects it
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b0;
      @(posedge clk); #1;
    end
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    idle(HALF + 3);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    chk("glitch_pulses",  32'(rdy_n), 32'd3);
    chk("glitch_ferr",    32'(ferr_n), 32'd0);

    // Stop bit low, then the line is held low (break)
    drive_frame(8'h3C, 1'b0, 8'h00, 10 * BP);
    for (int i = 0; i < 40; i++) begin
      rxd = 1'b0;
      @(posedge clk); #1;
    end
    chk("ferr_count",   32'(ferr_n), 32'd1);
    chk("ferr_out",     32'(out), 32'hFF);
    chk("ferr_pulses",  32'(rdy_n), 32'd3);
    chk("ferr_busy_hi", 32'(busy), 32'h1);
    idle(6);
    chk("ferr_busy_lo", 32'(busy), 32'h0);
    chk("ferr_once",    32'(ferr_n), 32'd1);

    // Reset during bit 4 of 0x5A, then a clean 0x81
    drive_frame(8'h5A, 1'b1, 8'h00, 5 * BP + 4);
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(4);
    chk("rst_mid_out",    32'(out), 32'h00);
    chk("rst_mid_busy",   32'(busy), 32'h0);
    chk("rst_mid_pulses", 32'(rdy_n), 32'd3);
    drive_frame(8'h81, 1'b1, 8'h00, 10 * BP);
    idle(8);
    chk("post_rst_pulses", 32'(rdy_n), 32'd4);
    chk("post_rst_byte",   32'(pulse_byte[3]), 32'h81);
    chk("post_rst_ferr",   32'(ferr_n), 32'd1);

    // One-cycle inverted glitch at each data-bit sample point
    drive_frame(8'h96, 1'b1, 8'hFF, 10 * BP);
    idle(8);
    chk("maj_pulses", 32'(rdy_n), 32'd5);
    chk("maj_byte",   32'(out), 32'(exp_glitch));

    chk("never_both", 32'(both_n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
